// File: rtl/fixed_point_mac_if.sv
// Beat and result signals between the FIR controller and the fixed-point MAC.
// The master drives operands and tags; the slave returns the saturated sum.
interface fixed_point_mac_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         first;
    logic         last;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic [N-1:0] result;
    logic         overflow;

    modport master (
        output in_valid, first, last, a, b,
        input  out_valid, result, overflow
    );

    modport slave (
        input  in_valid, first, last, a, b,
        output out_valid, result, overflow
    );
endinterface

// File: rtl/fixed_point_mac.sv
// Signed fixed-point MAC: full-precision accumulate with guard bits, saturated QN-F.F output.
// Latency: 3 cycles from the last beat to the out_valid pulse; 1 beat/cycle throughput.
// Backpressure: none; always accepts a beat, and bubbles (in_valid=0) hold the accumulator.
module fixed_point_mac #(
    parameter int N = 16,
    parameter int F = 8,
    parameter int G = 8
) (
    input  logic              clk,
    input  logic              rst,
    fixed_point_mac_if.slave  bus
);
    localparam int PW = 2 * N;
    localparam int AW = 2 * N + G;

    localparam logic signed [AW-1:0] SAT_MAX = {{(N+G+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(N+G+1){1'b1}}, {(N-1){1'b0}}};

    // Stage 1: product and beat tags
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] s1_prod;
    logic                 s1_vld;
    logic                 s1_first;
    logic                 s1_last;

    // Stage 2: accumulator and end-of-sum tag
    logic signed [AW-1:0] acc;
    logic                 s2_last_vld;

    // Stage 3 rescale/saturate
    logic signed [AW-1:0] shifted_c;
    logic                 sat_hi_c;
    logic                 sat_lo_c;
    logic        [N-1:0]  sat_res_c;

    logic                 out_valid_q;
    logic        [N-1:0]  result_q;
    logic                 overflow_q;

    always_comb begin
        prod_c = PW'($signed(bus.a)) * PW'($signed(bus.b));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_vld   <= bus.in_valid;
            s1_first <= bus.first;
            s1_last  <= bus.last;
            s1_prod  <= prod_c;
        end
    end

    // Sum wraps modulo 2^AW; guard bits absorb intermediate growth.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            s2_last_vld <= 1'b0;
        end else begin
            s2_last_vld <= s1_vld & s1_last;
            if (s1_vld) begin
                if (s1_first) begin
                    acc <= {{G{s1_prod[PW-1]}}, s1_prod};
                end else begin
                    acc <= acc + {{G{s1_prod[PW-1]}}, s1_prod};
                end
            end
        end
    end

    // Arithmetic shift truncates toward minus infinity before clamping.
    always_comb begin
        shifted_c = acc >>> F;
        sat_hi_c  = shifted_c > SAT_MAX;
        sat_lo_c  = shifted_c < SAT_MIN;
        if (sat_hi_c) begin
            sat_res_c = {1'b0, {(N-1){1'b1}}};
        end else if (sat_lo_c) begin
            sat_res_c = {1'b1, {(N-1){1'b0}}};
        end else begin
            sat_res_c = shifted_c[N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= s2_last_vld;
            if (s2_last_vld) begin
                result_q   <= sat_res_c;
                overflow_q <= sat_hi_c | sat_lo_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed and random checks of fixed_point_mac against a plain-arithmetic sum model.
module tb_fixed_point_mac;
    localparam int N  = 16;
    localparam int F  = 8;
    localparam int G  = 8;
    localparam int AW = 2 * N + G;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    fixed_point_mac_if #(.N(N)) bus ();

    fixed_point_mac #(.N(N), .F(F), .G(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t        pend[$];
    longint      macc = 0;
    logic [15:0] hold_res = '0;
    logic        hold_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    // Sum model: exact integer products, wrap to the accumulator width, floor-divide, clamp.
    task automatic model_beat(input bit f, input bit l, input logic [15:0] aa, input logic [15:0] bb);
        longint p;
        longint q;
        exp_t   e;
        p = longint'($signed(aa)) * longint'($signed(bb));
        if (f) macc = p;
        else   macc = macc + p;
        macc = (macc <<< (64 - AW)) >>> (64 - AW);
        if (l) begin
            q = macc >>> F;
            e.at = cyc + 3;
            if (q > 32767) begin
                e.res = 16'h7FFF; e.ovf = 1'b1;
            end else if (q < -32768) begin
                e.res = 16'h8000; e.ovf = 1'b1;
            end else begin
                e.res = q[15:0];  e.ovf = 1'b0;
            end
            pend.push_back(e);
        end
    endtask

    task automatic check_outputs();
        bit exp_v;
        exp_v = (pend.size() > 0) && (pend[0].at == cyc);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            hold_res = pend[0].res;
            hold_ovf = pend[0].ovf;
            void'(pend.pop_front());
        end
        chk("result", 32'(bus.result), 32'(hold_res));
        chk("overflow", 32'(bus.overflow), 32'(hold_ovf));
    endtask

    task automatic step(input bit v, input bit f, input bit l, input logic [15:0] aa, input logic [15:0] bb);
        bus.in_valid = v;
        bus.first    = f;
        bus.last     = l;
        bus.a        = aa;
        bus.b        = bb;
        if (v) model_beat(f, l, aa, bb);
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.first    = 1'b0;
        bus.last     = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        pend.delete();
        macc     = 0;
        hold_res = '0;
        hold_ovf = 1'b0;
        check_outputs();
    endtask

    // Single first=last beat, then explicit spec-value check at the pulse cycle.
    task automatic single(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic [15:0] r, input logic o);
        step(1'b1, 1'b1, 1'b1, aa, bb);
        idle(2);
        chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"}, 32'(bus.result), 32'(r));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(o));
        idle(1);
        chk({tag, "_pulse_end"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.first    = 1'b0;
        bus.last     = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        rst          = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        idle(2);

        single("pos", 16'h0180, 16'h0340, 16'h04E0, 1'b0);
        single("neg", 16'hFE80, 16'h0340, 16'hFB20, 1'b0);
        single("sat_hi", 16'h7F80, 16'h0540, 16'h7FFF, 1'b1);
        single("sat_lo", 16'h8000, 16'h0200, 16'h8000, 1'b1);
        single("trunc_pos", 16'h0001, 16'h0001, 16'h0000, 1'b0);
        single("trunc_neg", 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0);

        // Three taps with a bubble before the last
        step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200);
        step(1'b1, 1'b0, 1'b0, 16'h0080, 16'hFF00);
        idle(1);
        step(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0400);
        idle(2);
        chk("tap3_vld", 32'(bus.out_valid), 32'd1);
        chk("tap3_res", 32'(bus.result), 32'h0280);
        idle(2);

        // Reset mid-sum discards the partial sum and any pulse
        step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100);
        do_reset();
        step(1'b1, 1'b1, 1'b1, 16'h0200, 16'h0200);
        idle(2);
        chk("rst_mid_res", 32'(bus.result), 32'h0400);
        idle(2);

        // Back-to-back: last of A then single-beat B on the next cycle
        step(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0300);
        step(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0100);
        step(1'b1, 1'b1, 1'b1, 16'hFF00, 16'h0100);
        idle(1);
        chk("b2b_a_res", 32'(bus.result), 32'h0500);
        idle(1);
        chk("b2b_b_vld", 32'(bus.out_valid), 32'd1);
        chk("b2b_b_res", 32'(bus.result), 32'hFF00);
        idle(2);

        // Random sums: random lengths, bubbles, operand ranges; occasional orphan first=0 start
        for (int s = 0; s < 150; s++) begin
            int len;
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                logic [15:0] ra;
                logic [15:0] rb;
                bit          fst;
                ra  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
                rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
                fst = (k == 0) && ($urandom_range(0, 7) != 0);
                step(1'b1, fst, (k == len - 1), ra, rb);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(5);
        chk("scoreboard_drained", 32'(pend.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
